// File: rtl/uart_tx_out.sv
// uart_tx_out: queues bytes written to an output port in a 4-entry FIFO and
// shifts them out as back-to-back 8N1 frames (start, 8 data LSB first, stop).
module uart_tx_out #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output logic       overflow
);

  // Last value of the baud counter; reaching it closes the current bit period.
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [7:0]  mem_q [0:3];
  logic [7:0]  mem_d [0:3];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        overflow_q, overflow_d;

  logic        baud_done_s;
  logic        pop_s;
  logic        push_s;

  // Next-state logic for the transmit FSM, the FIFO and the status flags.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop_s      = 1'b0;
    push_s     = 1'b0;

    baud_done_s = (baud_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        // Pop as soon as anything is queued; the start bit appears on this edge.
        if (!empty_q) begin
          pop_s     = 1'b1;
          shift_d   = mem_q[rptr_q];
          state_d   = ST_START;
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          baud_d    = 16'd0;
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_done_s) begin
          baud_d = 16'd0;
          // Chain straight into the next start bit so frames have no gap.
          if (!empty_q) begin
            pop_s     = 1'b1;
            shift_d   = mem_q[rptr_q];
            state_d   = ST_START;
            bit_idx_d = 3'd0;
            tx_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        baud_d    = 16'd0;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    push_s = we && (!full_q || pop_s);

    if (push_s) begin
      mem_d[wptr_q] = data;
      wptr_d        = wptr_q + 2'd1;
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + 2'd1;
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (we && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    full_d  = (count_d == 3'd4);
    empty_d = (count_d == 3'd0);
    busy_d  = (state_d != ST_IDLE);
  end

  // State register; reset abandons any partial frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_q     <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      mem_q[0]   <= 8'd0;
      mem_q[1]   <= 8'd0;
      mem_q[2]   <= 8'd0;
      mem_q[3]   <= 8'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      count_q    <= 3'd0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_out.sv
// Bench for uart_tx_out: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_out;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_out #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .data     (data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Reference model: a byte queue plus "which cycle of which frame are we in".
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  bit         m_act;
  int         m_pos;
  bit         m_ovf;

  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level: frame bit number is cycle position divided by CLK_DIV.
  function automatic logic model_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = m_pos / D;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  task automatic model_step();
    if (reset) begin
      m_q.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      if (m_act) begin
        if (m_pos == 10 * D - 1) m_act = 1'b0;
        else m_pos++;
      end
      if (!m_act && m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_act = 1'b1;
        m_pos = 0;
      end
      if (we) begin
        if (m_q.size() < 4) m_q.push_back(data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tx",       32'(tx),       32'(model_tx()));
      chk("busy",     32'(busy),     32'(m_act));
      chk("count",    32'(count),    32'(m_q.size()));
      chk("full",     32'(full),     32'(m_q.size() == 4));
      chk("empty",    32'(empty),    32'(m_q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (busy === 1'b1) busy_cnt++;
      if (32'(count) > 32'(peak)) peak = 32'(count);
    end
  end

  logic [9:0] got;

  initial begin
    reset = 1'b1;
    we    = 1'b1;
    data  = 8'h5A;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_tx",       32'(tx),       32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    we    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_noqueue_busy", 32'(busy), 32'd0);

    // Single byte 0xA5.
    m_sent.delete();
    busy_cnt = 0;
    we = 1'b1; data = 8'hA5;
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) @(negedge clk);
      else repeat (D) @(negedge clk);
      got[i] = tx;
    end
    chk("a5_levels", 32'(got), 32'(10'b1101001010));
    repeat (10) @(negedge clk);
    chk("a5_busy_cycles", 32'(busy_cnt), 32'd40);
    chk("a5_idle_tx", 32'(tx), 32'd1);
    chk("a5_idle_busy", 32'(busy), 32'd0);
    chk("a5_sent_n", 32'(m_sent.size()), 32'd1);
    chk("a5_sent", 32'(m_sent[0]), 32'hA5);

    // Back-to-back 0x01..0x04.
    m_sent.delete();
    busy_cnt = 0;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; data = 8'(i + 1);
      @(negedge clk);
    end
    we = 1'b0;
    repeat (170) @(negedge clk);
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'd160);
    chk("b2b_peak", 32'(peak), 32'd3);
    chk("b2b_sent_n", 32'(m_sent.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("b2b_sent", 32'(m_sent[i]), 32'(i + 1));

    // Overflow with 0x11..0x16.
    m_sent.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("ovf_full_n4", 32'(full), 32'd1);
      we = 1'b1; data = 8'(8'h11 + i);
      @(negedge clk);
    end
    we = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    repeat (5 * 40 + 20) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_sent_n", 32'(m_sent.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("ovf_sent", 32'(m_sent[i]), 32'(8'h11 + i));

    // Push on a full FIFO at the edge that ends a stop bit.
    m_sent.delete();
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; data = 8'(8'h71 + i);
      @(negedge clk);
    end
    we = 1'b0;
    repeat (36) @(negedge clk);
    chk("pf_full_before", 32'(full), 32'd1);
    we = 1'b1; data = 8'h77;
    @(negedge clk);
    we = 1'b0;
    chk("pf_count", 32'(count), 32'd4);
    chk("pf_start_tx", 32'(tx), 32'd0);
    repeat (5 * 40 + 10) @(negedge clk);
    chk("pf_sent_n", 32'(m_sent.size()), 32'd6);
    chk("pf_last", 32'(m_sent[5]), 32'h77);

    // Reset during data bit 3 of 0x00 with two bytes queued.
    m_sent.delete();
    we = 1'b1; data = 8'h00; @(negedge clk);
    data = 8'hAA; @(negedge clk);
    data = 8'hBB; @(negedge clk);
    we = 1'b0;
    repeat (15) @(negedge clk);
    chk("mr_count_before", 32'(count), 32'd2);
    chk("mr_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_tx", 32'(tx), 32'd1);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_overflow", 32'(overflow), 32'd0);
    busy_cnt = 0;
    repeat (100) @(negedge clk);
    chk("mr_no_frames", 32'(busy_cnt), 32'd0);
    chk("mr_sent_n", 32'(m_sent.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
